// File: rtl/edge_counter_pkg.sv
// Shared types and constants for the timed command scheduler.
package edge_counter_pkg;

    // Bit indices of the command word understood by the edge-counter controller.
    localparam int unsigned CMD_START = 0;
    localparam int unsigned CMD_STOP  = 1;
    localparam int unsigned CMD_SAVE  = 2;
    localparam int unsigned CMD_RESET = 3;
    localparam int unsigned CMD_BITS  = 4;

    localparam int unsigned TS_W      = 64;
    localparam int unsigned CMD_W     = 64;
    localparam int unsigned REC_W     = TS_W + CMD_W;

    // Queued record: only the meaningful command bits are kept.
    typedef struct packed {
        logic [TS_W-1:0]     ts;
        logic [CMD_BITS-1:0] cmd;
    } cmd_rec_t;

endpackage

// File: rtl/edge_counter_cmd_scheduler_if.sv
// Host-side record stream: timestamped command records with valid/ready handshake.
interface edge_counter_cmd_scheduler_if;
    import edge_counter_pkg::*;

    logic [REC_W-1:0] s_data;
    logic             s_valid;
    logic             s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/sched_fifo.sv
// Single-clock FIFO of command records with first-word-fall-through head.
module sched_fifo
    import edge_counter_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push_i,
    input  cmd_rec_t                   push_rec_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output cmd_rec_t                   head_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    cmd_rec_t            mem_q [DEPTH];
    logic [PtrW-1:0]     wptr_q, wptr_d;
    logic [PtrW-1:0]     rptr_q, rptr_d;
    logic [LvlW-1:0]     level_q, level_d;
    logic                do_push, do_pop;

    assign full_o  = (level_q == LvlW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign head_o  = mem_q[rptr_q];

    // Overflow/underflow requests are ignored; flush overrides both.
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    // Next-state pointers and occupancy.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    // Pointer and level registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage needs no reset: level gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= push_rec_i;
    end

endmodule

// File: rtl/edge_counter_cmd_scheduler.sv
// Timed command sequencer: issues each queued command when counter reaches its timestamp.
module edge_counter_cmd_scheduler
    import edge_counter_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned TS_WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [TS_WIDTH-1:0]        counter,
    edge_counter_cmd_scheduler_if.slave s_if,
    input  logic                       flush,
    input  logic                       clear_late,
    output logic [CMD_W-1:0]           cmd_out,
    output logic                       late,
    output logic [$clog2(DEPTH):0]     level
);

    cmd_rec_t             push_rec;
    cmd_rec_t             head;
    logic                 full, empty;
    logic                 push, due, issue, is_late;
    logic [CMD_W-1:0]     cmd_out_q, cmd_out_d;
    logic                 late_q, late_d;
    logic                 unused_data;

    // Command bits above CMD_BITS carry no meaning and are dropped at the door.
    assign unused_data   = ^s_if.s_data[CMD_W-1:CMD_BITS];
    assign push_rec.ts   = s_if.s_data[REC_W-1:CMD_W];
    assign push_rec.cmd  = s_if.s_data[CMD_BITS-1:0];

    assign s_if.s_ready  = ~full & ~flush;
    assign push          = s_if.s_valid & s_if.s_ready;

    // Head is due once the unsigned counter has reached its timestamp; flush suppresses issue.
    assign due     = ~empty & (counter >= head.ts);
    assign issue   = due & ~flush;
    assign is_late = counter > head.ts;

    sched_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push_i     (push),
        .push_rec_i (push_rec),
        .pop_i      (issue),
        .flush_i    (flush),
        .head_o     (head),
        .level_o    (level),
        .full_o     (full),
        .empty_o    (empty)
    );

    // Next command word and sticky late flag; a set beats a same-cycle clear.
    always_comb begin
        cmd_out_d = '0;
        late_d    = late_q;
        if (issue) begin
            cmd_out_d[CMD_BITS-1:0] = head.cmd;
        end
        if (issue && is_late) begin
            late_d = 1'b1;
        end else if (clear_late) begin
            late_d = 1'b0;
        end
    end

    // Output registers; cmd_out is a single-cycle pulse, never held.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cmd_out_q <= '0;
            late_q    <= 1'b0;
        end else begin
            cmd_out_q <= cmd_out_d;
            late_q    <= late_d;
        end
    end

    assign cmd_out = cmd_out_q;
    assign late    = late_q;

endmodule

// File: doc/edge_counter_cmd_scheduler.md
# edge_counter_cmd_scheduler

Timed command sequencer placed directly upstream of the edge-counter controller. It accepts timestamped command records from the host-side stream, buffers them in order, and when the free-running 64-bit `counter` reaches each record's timestamp it drives a one-cycle command word onto the controller's `cmd_in`. Commands are START, STOP, SAVE and RESET. This gives cycle-exact gate windows and readout instants without host-latency jitter.

## Interface
- `DEPTH`, 8 — FIFO entries; power of two, ≥ 2.
- `TS_WIDTH`, 64 — timestamp width; equals `counter` width.

Ports:
- `clk`  in  1  — single system clock.
- `resetn`  in  1  — **one clock; reset is asynchronous and active-low.**
- `counter`  in  64  — free-running timestamp; same value fed to the controller.
- `s_data`  in  128  — command record.
  - [127:64] issue timestamp.
  - [63:0] command word; only [3:0] meaningful: bit0 START, bit1 STOP, bit2 SAVE, bit3 RESET.
- `s_valid`  in  1  — record offered.
- `s_ready`  out  1  — record can be accepted.
- `flush`  in  1  — synchronous; discards all queued records.
- `clear_late`  in  1  — clears `late`.
- `cmd_out`  out  64  — to controller `cmd_in`.
- `late`  out  1  — sticky; some record issued after its timestamp.
- `level`  out  $clog2(DEPTH)+1  — entries currently queued.

## Operation
- **Push:** accept when `s_valid & s_ready`. Store timestamp and command bits [3:0]; bits [63:4] are discarded.
- **Ready:** `s_ready = (level != DEPTH) & ~flush`. It is combinational from registered state.
- **Due:** head entry is due when the FIFO is non-empty and `counter >= head_ts`, using a 64-bit unsigned compare. No wrap handling: 64-bit `counter` does not wrap in service.
- **Issue:** when the head is due at a clock edge, the head is popped and `cmd_out[3:0]` is registered with its bits; `cmd_out[63:4]` is always 0. Otherwise `cmd_out` is registered 0, so it is never held across cycles.
- **Late:** at issue, if `counter > head_ts` (strictly), set `late`. `clear_late` clears it. If set and clear occur in the same cycle, set wins.
- **Issue rate:** at most one record per cycle. Records with past timestamps drain on consecutive cycles in FIFO order.
- **Ordering:** issue is strictly in push order; timestamps are never reordered. A non-monotonic record blocks later ones until it is due.
- **Push with pop:** simultaneous push and pop in the same cycle leaves `level` unchanged. A push to an empty FIFO cannot pop in the same cycle.
- **Flush:**
  - Next edge: pointers and `level` go to 0 and `cmd_out` is registered 0.
  - No issue occurs on the flush edge.
  - A push in the same cycle is refused, because `s_ready` is 0.
  - `late` is unaffected.
- **Empty commands:** a record with all command bits zero is still popped at its time. It produces `cmd_out = 0` and can still set `late`.

## Timing
- Reset (`resetn` low, asynchronous) sets:
  - `cmd_out` = 0, `late` = 0, `level` = 0;
  - pointers = 0;
  - `s_ready` = 1 once `resetn` is high.
- **Latency, timestamp in the past:** record pushed at edge N becomes head after edge N. Due is evaluated in cycle N+1, so `cmd_out` is valid in cycle N+2.
- **Latency, future timestamp T:** `cmd_out` is valid in the cycle after the edge where `counter == T` is sampled. `counter` is T+1 at that point, matching the controller's one-cycle register stage.
- **Reset mid-operation:** all queued records are lost and any in-flight `cmd_out` pulse is cut immediately.

## Structure
- Package `edge_counter_pkg`:
  - `CMD_START=0`, `CMD_STOP=1`, `CMD_SAVE=2`, `CMD_RESET=3` bit indices;
  - `CMD_BITS=4`;
  - `cmd_rec_t` packed struct {ts[63:0], cmd[3:0]}.
- Sub-module `sched_fifo`: synchronous single-clock FIFO of `cmd_rec_t`, DEPTH entries, with first-word visible on `head`, push, pop, flush, level and full/empty. The top level holds the due compare, issue register and late flag.

## Test plan
- **Reset:** reset, then push {ts=100, cmd=START} at counter=10 → `cmd_out` = 64'h1 for exactly one cycle, with counter=101 in that cycle; `late` = 0; `level` returns to 0.
- **Late:** push {ts=5, SAVE}, {ts=6, STOP} while counter=50 → `cmd_out` = 4, then 2, in consecutive cycles starting 2 cycles after the first push; `late` = 1. Then `clear_late` → `late` = 0.
- **Full:** with DEPTH=8, push 8 future records → `level` = 8 and `s_ready` = 0; a 9th `s_valid` is not accepted. Issue the first → `s_ready` returns to 1.
- **Bit masking:** push {ts=20, cmd=64'hFFFF_0009} → `cmd_out` = 64'h9 at issue; upper bits are 0.
- **Flush:** queue 3 records, assert `flush` one cycle with `s_valid` high → `level` = 0, no `cmd_out` pulses at the later timestamps, and the concurrent record is not accepted.
- **Async reset:** deassert `resetn` asynchronously during a `cmd_out` pulse → `cmd_out` = 0 immediately, queue empty after release.
